// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// A bubble is an all-zero bundle, so forwarding never matches it.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              regWriteID,
  input  logic              memReadID,
  input  logic              memWriteID,
  input  logic              memToRegID,
  input  logic              aluSrcID,
  input  logic              regDstID,
  input  logic [3:0]        aluOpID,
  input  logic [DATA_W-1:0] readData1ID,
  input  logic [DATA_W-1:0] readData2ID,
  input  logic [DATA_W-1:0] immID,
  input  logic [REG_W-1:0]  registerRsID,
  input  logic [REG_W-1:0]  registerRtID,
  input  logic [REG_W-1:0]  registerRdID,
  input  logic              validID,
  output logic              regWriteEX,
  output logic              memReadEX,
  output logic              memWriteEX,
  output logic              memToRegEX,
  output logic              aluSrcEX,
  output logic              regDstEX,
  output logic              validEX,
  output logic [3:0]        aluOpEX,
  output logic [DATA_W-1:0] readData1EX,
  output logic [DATA_W-1:0] readData2EX,
  output logic [DATA_W-1:0] immEX,
  output logic [REG_W-1:0]  registerRsEX,
  output logic [REG_W-1:0]  registerRtEX,
  output logic [REG_W-1:0]  registerRdEX,
  output logic [REG_W-1:0]  writeRegEX,
  output logic              stall,
  output logic [CNT_W-1:0]  bubbleCount
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic              valid;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } ex_bundle_t;

  ex_bundle_t       r_ex;
  ex_bundle_t       w_id;
  logic [CNT_W-1:0] r_bubble_count;
  logic             w_stall;
  logic             w_rt_match;

  assign w_id = '{reg_write: regWriteID, mem_read: memReadID, mem_write: memWriteID,
                  mem_to_reg: memToRegID, alu_src: aluSrcID, reg_dst: regDstID,
                  valid: validID, alu_op: aluOpID, rd1: readData1ID, rd2: readData2ID,
                  imm: immID, rs: registerRsID, rt: registerRtID, rd: registerRdID};

  assign w_rt_match = (r_ex.rt == registerRsID) || (r_ex.rt == registerRtID);
  assign w_stall    = !hold && r_ex.mem_read && r_ex.valid && (r_ex.rt != '0) &&
                      validID && w_rt_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex           <= '0;
      r_bubble_count <= '0;
    end else if (!hold) begin
      if (flush || w_stall) begin
        r_ex <= '0;
        // flush wins over stall, so only hazard-only bubbles are counted
        if (!flush && (r_bubble_count != '1))
          r_bubble_count <= r_bubble_count + 1'b1;
      end else begin
        r_ex <= w_id;
      end
    end
  end

  assign regWriteEX   = r_ex.reg_write;
  assign memReadEX    = r_ex.mem_read;
  assign memWriteEX   = r_ex.mem_write;
  assign memToRegEX   = r_ex.mem_to_reg;
  assign aluSrcEX     = r_ex.alu_src;
  assign regDstEX     = r_ex.reg_dst;
  assign validEX      = r_ex.valid;
  assign aluOpEX      = r_ex.alu_op;
  assign readData1EX  = r_ex.rd1;
  assign readData2EX  = r_ex.rd2;
  assign immEX        = r_ex.imm;
  assign registerRsEX = r_ex.rs;
  assign registerRtEX = r_ex.rt;
  assign registerRdEX = r_ex.rd;
  assign writeRegEX   = r_ex.reg_dst ? r_ex.rd : r_ex.rt;
  assign stall        = w_stall;
  assign bubbleCount  = r_bubble_count;

endmodule
